alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Operand issue stage directly upstream of the parameterised ALU. It accepts decoded operations (src_a, src_b, ALU_Control) from the decode/register-read side over a valid/ready handshake.
- Operations are buffered in a 2-entry FIFO skid buffer. The stage drives the ALU operand and control inputs and presents each op downstream with valid/ready.
- It captures the ALU result and zero flag of every issued op, so the next op can forward the previous result into either operand without a register-file round trip.

Parameters:
- WIDTH, 32, datapath width of src_a, src_b, ALU_out and the result register. Must match the ALU instance parameter.

Ports:
- clk  input  1  single system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream op valid
- in_ready  output  1  stage can accept an op this cycle
- in_src_a  input  WIDTH  operand A from register read
- in_src_b  input  WIDTH  operand B from register read
- in_alu_control  input  2  ALU operation code
- in_fwd_a  input  1  replace A with previous ALU result
- in_fwd_b  input  1  replace B with previous ALU result
- src_a  output  WIDTH  operand A to ALU
- src_b  output  WIDTH  operand B to ALU
- ALU_Control  output  2  op code to ALU
- out_valid  output  1  head op presented to ALU/downstream
- out_ready  input  1  downstream consumes the head op this cycle
- alu_out  input  WIDTH  ALU result for the currently presented op (combinational from ALU)
- alu_zero  input  1  ALU zero flag for the currently presented op
- last_result  output  WIDTH  result of the most recently issued op
- last_zero  output  1  zero flag of the most recently issued op

Behaviour:
- Reset (async, reset_n=0) clears: FIFO count=0, read/write pointers=0, last_result=0, last_zero=0. Output values during and after reset: in_ready=1, out_valid=0, src_a=0, src_b=0, ALU_Control=2'b00.
- Reset asserted mid-operation discards all buffered ops immediately; no handshake completes in that cycle.
- Push: in_valid && in_ready on a rising edge writes {in_src_a, in_src_b, in_alu_control, in_fwd_a, in_fwd_b} at the write pointer.
- Pop: out_valid && out_ready on a rising edge removes the head entry.
- in_ready = (count < 2). It is a function of registered count only, with no combinational path from out_ready.
- out_valid = (count != 0). No bypass: latency from push to out_valid is exactly 1 cycle.
- Simultaneous push and pop: count unchanged, both pointers advance. This occurs only at count 1, since at count 2 in_ready=0.
- Pointers are 1 bit and wrap 1 -> 0. Count transitions: 0 -> 1 (push), 1 -> 2 (push), 2 -> 1 (pop), 1 -> 0 (pop), 1 -> 1 (push+pop).
- Operand mux (combinational from head entry):
  - src_a = head.fwd_a ? last_result : head.src_a
  - src_b = head.fwd_b ? last_result : head.src_b
  - ALU_Control = head.alu_control
- When out_valid=0, src_a/src_b/ALU_Control are driven to 0.
- Result capture: on each pop, last_result <= alu_out and last_zero <= alu_zero. The values are held until the next pop.
- Forward semantics: forwarding always refers to the op popped immediately before the head. Because last_result updates at the pop edge, a back-to-back dependent op sees the new value in its first cycle at head.
- Forwarding before any op has issued since reset yields 0.
- No arithmetic in this block. All operand widths are WIDTH; ALU_Control is 2 bits and is passed unmodified.

Decomposition:
- Shared package alu_pkg:
  - alu_ctrl_t (2-bit enum): ALU_OP0..ALU_OP3 = 2'b00..2'b11, matching the ALU decode
  - issue_entry_t packed struct {src_a, src_b, alu_ctrl, fwd_a, fwd_b}, parameterised via WIDTH at use site
- One sub-module, issue_fifo2: 2-entry FIFO holding issue_entry_t with count/pointers and the in_ready/out_valid logic.
- Operand mux and result capture stay in the top module.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, src_a=0, src_b=0, ALU_Control=0, last_result=0.
- Push {a=5, b=3, ctrl=00}, out_ready=1, ALU model returns 8 -> out_valid the cycle after the push, src_a=5, src_b=3; after the pop, last_result=8, last_zero=0.
- Hold out_ready=0, push 3 ops back-to-back -> in_ready falls to 0 after the 2nd push; the 3rd op is held upstream. Raise out_ready -> ops emerge in order and in_ready returns to 1 one cycle after the first pop.
- Dependent chain: op1 {a=7, b=7, ctrl=01} with ALU model result 0, then op2 {fwd_a=1, b=4, ctrl=00} -> op2 presents src_a=0, src_b=4; last_zero=1 after op1 pops.
- Forward on both operands right after reset, {fwd_a=1, fwd_b=1, a=9, b=9} -> src_a=0, src_b=0.
- Assert reset_n=0 while count=2 -> out_valid drops to 0 immediately (asynchronously), in_ready=1, last_result=0; the first op pushed after release presents its own operands.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue path: op codes and the buffered issue entry.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    ALU_OP0 = 2'b00,
    ALU_OP1 = 2'b01,
    ALU_OP2 = 2'b10,
    ALU_OP3 = 2'b11
  } alu_ctrl_t;

  // Default-width entry; the top redeclares the same layout at its own WIDTH.
  typedef struct packed {
    logic [ALU_WIDTH-1:0] src_a;
    logic [ALU_WIDTH-1:0] src_b;
    alu_ctrl_t            alu_ctrl;
    logic                 fwd_a;
    logic                 fwd_b;
  } issue_entry_t;

endpackage

// File: rtl/issue_fifo2.sv
// Two-entry skid FIFO for issue entries; ready/valid depend only on the registered count.
module issue_fifo2
  import alu_pkg::*;
#(
  parameter type entry_t = issue_entry_t
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push_valid,
  output logic   push_ready,
  input  entry_t push_data,
  output logic   pop_valid,
  input  logic   pop_ready,
  output entry_t pop_data
);

  localparam logic [1:0] DEPTH = 2'd2;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign push_ready = (count < DEPTH);
  assign pop_valid  = (count != 2'd0);
  assign pop_data   = mem[rd_ptr];
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU operand issue stage: buffers decoded ops, muxes forwarded results into the
// operands and captures each issued op's result and zero flag.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_src_a,
  input  logic [WIDTH-1:0] in_src_b,
  input  logic [1:0]       in_alu_control,
  input  logic             in_fwd_a,
  input  logic             in_fwd_b,
  output logic [WIDTH-1:0] src_a,
  output logic [WIDTH-1:0] src_b,
  output logic [1:0]       ALU_Control,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] last_result,
  output logic             last_zero
);

  typedef struct packed {
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    alu_ctrl_t        alu_ctrl;
    logic             fwd_a;
    logic             fwd_b;
  } stage_entry_t;

  stage_entry_t push_entry;
  stage_entry_t head;

  always_comb begin
    push_entry          = '0;
    push_entry.src_a    = in_src_a;
    push_entry.src_b    = in_src_b;
    push_entry.alu_ctrl = alu_ctrl_t'(in_alu_control);
    push_entry.fwd_a    = in_fwd_a;
    push_entry.fwd_b    = in_fwd_b;
  end

  issue_fifo2 #(
    .entry_t (stage_entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head)
  );

  // Operand mux: forwarded operands take the result of the op popped just before the head.
  always_comb begin
    src_a       = '0;
    src_b       = '0;
    ALU_Control = 2'b00;
    if (out_valid) begin
      src_a       = head.fwd_a ? last_result : head.src_a;
      src_b       = head.fwd_b ? last_result : head.src_b;
      ALU_Control = head.alu_ctrl;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_result <= '0;
      last_zero   <= 1'b0;
    end else if (out_valid && out_ready) begin
      last_result <= alu_out;
      last_zero   <= alu_zero;
    end
  end

endmodule
